// File: rtl/song_beat_sequencer.sv
// Beat sequencer for the note-highway display: paces song-register shifts at a fixed
// tempo, hands each new frame to the drawer and waits for its done handshake.
module song_beat_sequencer #(
    parameter int unsigned BEAT_CYCLES = 50_000_000,
    parameter int unsigned SONG_LEN    = 5,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned TMP_W       = 26
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             draw_done,
    input  logic             pause,
    input  logic             loop_en,
    output logic             shift_song,
    output logic             beat_tick,
    output logic             song_done,
    output logic             busy,
    output logic             beat_overrun,
    output logic [CNT_W-1:0] song_counter
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_BEAT,
        SHIFT,
        DRAW,
        WAIT_DRAW,
        DONE
    } state_t;

    localparam logic [TMP_W-1:0] TEMPO_LAST = TMP_W'(BEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(SONG_LEN);

    state_t           state;
    state_t           stateNext;
    logic [TMP_W-1:0] tempoCount;
    logic             beatPending;
    logic             tempoRun;
    logic             tempoWrap;

    // The tempo keeps running through shift/draw so the beat period never stretches.
    always_comb begin
        tempoRun  = 1'b0;
        tempoWrap = 1'b0;
        if ((state == WAIT_BEAT || state == SHIFT || state == DRAW || state == WAIT_DRAW)
            && !pause) begin
            tempoRun  = 1'b1;
            tempoWrap = (tempoCount == TEMPO_LAST);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext  = state;
        shift_song = 1'b0;
        beat_tick  = 1'b0;
        song_done  = 1'b0;
        busy       = 1'b1;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    stateNext = START;
                end
            end
            START: begin
                stateNext = WAIT_BEAT;
            end
            WAIT_BEAT: begin
                if (beatPending && !pause) begin
                    stateNext = SHIFT;
                end
            end
            SHIFT: begin
                shift_song = 1'b1;
                stateNext  = DRAW;
            end
            DRAW: begin
                beat_tick = 1'b1;
                stateNext = WAIT_DRAW;
            end
            WAIT_DRAW: begin
                if (draw_done) begin
                    if (song_counter == LAST_BEAT) begin
                        stateNext = loop_en ? START : DONE;
                    end else begin
                        stateNext = WAIT_BEAT;
                    end
                end
            end
            DONE: begin
                song_done = 1'b1;
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tempoCount   <= '0;
            beatPending  <= 1'b0;
            beat_overrun <= 1'b0;
            song_counter <= '0;
        end else if (state == START) begin
            tempoCount   <= '0;
            beatPending  <= 1'b0;
            beat_overrun <= 1'b0;
            song_counter <= '0;
        end else begin
            if (tempoRun) begin
                tempoCount <= tempoWrap ? '0 : tempoCount + TMP_W'(1);
            end
            // A wrap coinciding with SHIFT's consume re-arms the beat rather than losing it.
            if (tempoWrap) begin
                beatPending <= 1'b1;
            end else if (state == SHIFT) begin
                beatPending <= 1'b0;
            end
            if (tempoWrap && beatPending && state != SHIFT) begin
                beat_overrun <= 1'b1;
            end
            if (state == DRAW) begin
                song_counter <= song_counter + CNT_W'(1);
            end
        end
    end

endmodule
